// File: rtl/led_pwm_drive_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : led_pwm_drive_pkg
//  Purpose : Shared constants and types for the LED PWM pin driver:
//            register addresses, reset values and the BLINKEN bit layout.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package led_pwm_drive_pkg;

  // Register addresses on the peripheral bus
  localparam logic [1:0] ADDR_DUTY    = 2'd0;
  localparam logic [1:0] ADDR_BLINKEN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Reset values: full brightness, blinking disabled
  localparam logic [7:0]  DUTY_RST   = 8'hFF;
  localparam logic [15:0] PERIOD_RST = 16'h0000;

  // BLINKEN bit ordering: {red2..red0, green2..green0}
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
  } blinken_t;

  localparam int BLINKEN_W = $bits(blinken_t);

endpackage
`default_nettype wire

// File: rtl/led_pwm_drive_if.sv
`default_nettype none
// ============================================================================
//  Module  : led_pwm_drive_if
//  Purpose : Peripheral bus bundle for the LED PWM register file.
//  Signals : Addr[1:0] register select, DataWr[15:0] write data,
//            DataRd[15:0] read data, En block select, Rd read strobe,
//            Wr write strobe.
//  Modports: master (bus driver), slave (register file).
//  Rev     : 1.0  initial release
// ============================================================================
interface led_pwm_drive_if;
  logic [1:0]  Addr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        En;
  logic        Rd;
  logic        Wr;

  modport master (output Addr, DataWr, En, Rd, Wr, input DataRd);
  modport slave  (input Addr, DataWr, En, Rd, Wr, output DataRd);
endinterface
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ============================================================================
//  Module  : led_pwm_timebase
//  Purpose : Prescaler, PWM step counter, frame_end strobe and the shadowed
//            active duty that produces the global pwm_on level.
//  Ports   : Clk, Reset (async active-low), pending_duty (from register
//            file), frame_end (last step of a PWM frame), pwm_on, pwm_cnt.
//  Rev     : 1.0  initial release
// ============================================================================
module led_pwm_timebase
  import led_pwm_drive_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int PWM_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PWM_BITS-1:0] pending_duty,
  output logic                frame_end,
  output logic                pwm_on,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  // CLK_DIV=1 still needs a one-bit prescaler that simply stays at zero
  localparam int                  c_pre_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_pre_w-1:0]  c_pre_max  = c_pre_w'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] c_cnt_max  = '1;

  logic [c_pre_w-1:0]  r_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_active;
  logic                w_tick;

  assign w_tick    = (r_pre == c_pre_max);
  assign frame_end = w_tick & (r_cnt == c_cnt_max);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      r_active <= PWM_BITS'(DUTY_RST);
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick)
        r_cnt <= r_cnt + 1'b1;
      // Duty only changes on a frame boundary so a frame is never cut short
      if (frame_end)
        r_active <= pending_duty;
    end
  end

  // All-ones duty is forced fully on; otherwise compare against the step count
  assign pwm_on  = (r_active == c_cnt_max) | (r_cnt < r_active);
  assign pwm_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/led_pwm_drive.sv
`default_nettype none
// ============================================================================
//  Module  : led_pwm_drive
//  Purpose : Drives the six LED pins: combines LedGreen/LedRed enables with a
//            global PWM brightness and per-LED blinking; registered pins.
//  Ports   : Clk, Reset (async active-low), bus (register file slave port),
//            LedGreen[2:0]/LedRed[2:0] enables in, PinGreen[2:0]/PinRed[2:0]
//            registered active-high pin drives out.
//  Rev     : 1.0  initial release
// ============================================================================
module led_pwm_drive
  import led_pwm_drive_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int PWM_BITS = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  led_pwm_drive_if.slave        bus,
  input  logic [2:0]            LedGreen,
  input  logic [2:0]            LedRed,
  output logic [2:0]            PinGreen,
  output logic [2:0]            PinRed
);

  logic [PWM_BITS-1:0] r_duty;
  blinken_t            r_blinken;
  logic [15:0]         r_period;
  logic [15:0]         r_blink_cnt;
  logic                r_blink_phase;
  logic [15:0]         w_data_rd;
  logic                w_wr;
  logic                w_period_wr;
  logic                w_frame_end;
  logic                w_pwm_on;
  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic [2:0]          w_gate_green;
  logic [2:0]          w_gate_red;
  logic                w_unused_rd;

  // Reads have no side effects, so the read strobe is not needed
  assign w_unused_rd = bus.Rd;

  assign w_wr        = bus.Wr & bus.En;
  assign w_period_wr = w_wr & (bus.Addr == ADDR_PERIOD);

  led_pwm_timebase #(
    .CLK_DIV  (CLK_DIV),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .Clk          (Clk),
    .Reset        (Reset),
    .pending_duty (r_duty),
    .frame_end    (w_frame_end),
    .pwm_on       (w_pwm_on),
    .pwm_cnt      (w_pwm_cnt)
  );

  // Register file; STATUS is read-only so writes to it fall through
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_duty    <= PWM_BITS'(DUTY_RST);
      r_blinken <= '0;
      r_period  <= PERIOD_RST;
    end else if (w_wr) begin
      case (bus.Addr)
        ADDR_DUTY:    r_duty    <= bus.DataWr[PWM_BITS-1:0];
        ADDR_BLINKEN: r_blinken <= blinken_t'(bus.DataWr[BLINKEN_W-1:0]);
        ADDR_PERIOD:  r_period  <= bus.DataWr;
        default:      ;
      endcase
    end
  end

  // Blink timer counts frames; a PERIOD write restarts it in the lit phase
  // and wins over a coincident frame_end.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_period_wr || (r_period == 16'd0)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_frame_end) begin
      if (r_blink_cnt == r_period - 16'd1) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 16'd1;
      end
    end
  end

  // A LED is gated off only when blinking is enabled and in the dark phase
  assign w_gate_green = ~r_blinken.green | {3{r_blink_phase}};
  assign w_gate_red   = ~r_blinken.red   | {3{r_blink_phase}};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PinGreen <= '0;
      PinRed   <= '0;
    end else begin
      PinGreen <= LedGreen & {3{w_pwm_on}} & w_gate_green;
      PinRed   <= LedRed   & {3{w_pwm_on}} & w_gate_red;
    end
  end

  always_comb begin
    w_data_rd = '0;
    case (bus.Addr)
      ADDR_DUTY:    w_data_rd = {{(16-PWM_BITS){1'b0}}, r_duty};
      ADDR_BLINKEN: w_data_rd = {{(16-BLINKEN_W){1'b0}}, r_blinken};
      ADDR_PERIOD:  w_data_rd = r_period;
      default:      w_data_rd = {{(15-PWM_BITS){1'b0}}, r_blink_phase, w_pwm_cnt};
    endcase
  end

  assign bus.DataRd = w_data_rd;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_drive.sv
`default_nettype none
// ============================================================================
//  Module  : tb_led_pwm_drive
//  Purpose : Self-checking bench for led_pwm_drive (CLK_DIV=2): register
//            table, shadowed duty, blink timing, simultaneity, async reset
//            and randomized traffic against a frame-arithmetic model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_led_pwm_drive;
  import led_pwm_drive_pkg::*;

  localparam int D  = 2;
  localparam int FR = 256 * D;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] LedGreen, LedRed;
  logic [2:0] PinGreen, PinRed;

  led_pwm_drive_if bus_if ();

  led_pwm_drive #(.CLK_DIV(D), .PWM_BITS(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus_if),
    .LedGreen (LedGreen),
    .LedRed   (LedRed),
    .PinGreen (PinGreen),
    .PinRed   (PinRed)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time since reset in cycles, frame_ends since the last
  // PERIOD write, and the architectural registers.
  int unsigned m_t, m_nfe;
  logic [7:0]  m_pend, m_act;
  logic [5:0]  m_ben;
  logic [15:0] m_per;
  logic [15:0] rd_val;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
    logic        en;
    logic [15:0] exp_duty;
    logic [15:0] exp_ben;
    logic [15:0] exp_per;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_phase();
    if (m_per == 16'd0) return 1'b1;
    return ((m_nfe / m_per) % 2) == 0;
  endfunction

  function automatic logic [7:0] model_cnt();
    return 8'((m_t / D) % 256);
  endfunction

  function automatic logic [15:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {8'h00, m_pend};
      2'd1:    return {10'h000, m_ben};
      2'd2:    return m_per;
      default: return {7'h00, model_phase(), model_cnt()};
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_nfe = 0; m_pend = 8'hFF; m_act = 8'hFF; m_ben = '0; m_per = '0;
  endtask

  // One clock: called and returns at a negedge; checks read data and pins.
  task automatic cyc(input logic [1:0] a, input logic [15:0] d, input logic wr, input logic en);
    logic [7:0] cnt;
    logic       fe, on, ph;
    logic [2:0] eg, er;
    bus_if.Addr = a; bus_if.DataWr = d; bus_if.Wr = wr; bus_if.En = en; bus_if.Rd = ~wr;
    #1;
    rd_val = bus_if.DataRd;
    chk("data_rd", rd_val, model_rd(a));
    cnt = model_cnt();
    fe  = ((m_t % D) == D - 1) && (cnt == 8'hFF);
    on  = (m_act == 8'hFF) || (cnt < m_act);
    ph  = model_phase();
    eg  = LedGreen & {3{on}} & (~m_ben[2:0] | {3{ph}});
    er  = LedRed   & {3{on}} & (~m_ben[5:3] | {3{ph}});
    @(posedge Clk);
    if (fe) m_act = m_pend;
    if (wr && en) begin
      case (a)
        2'd0:    m_pend = d[7:0];
        2'd1:    m_ben  = d[5:0];
        2'd2:    m_per  = d;
        default: ;
      endcase
    end
    if (wr && en && a == 2'd2) m_nfe = 0;
    else if (fe) m_nfe++;
    m_t++;
    @(negedge Clk);
    chk("pin_green", PinGreen, eg);
    chk("pin_red", PinRed, er);
  endtask

  task automatic idle();
    cyc(ADDR_STATUS, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic align_start();
    for (int i = 0; i < FR && (m_t % FR) != 0; i++) idle();
  endtask

  task automatic frame_count(output int g0, output int g1);
    g0 = 0; g1 = 0;
    for (int i = 0; i < FR; i++) begin
      idle();
      g0 += int'(PinGreen[0]);
      g1 += int'(PinGreen[1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int g0, g1, n, hi, wraps;
    logic [7:0] prev;
    logic found;
    logic [1:0] ra;
    logic [15:0] rdat;
    int exp_b0[4];

    tbl[0] = '{ADDR_DUTY,    16'h1234, 1'b1, 16'h0034, 16'h0000, 16'h0000};
    tbl[1] = '{ADDR_BLINKEN, 16'hFFFF, 1'b1, 16'h0034, 16'h003F, 16'h0000};
    tbl[2] = '{ADDR_PERIOD,  16'hABCD, 1'b1, 16'h0034, 16'h003F, 16'hABCD};
    tbl[3] = '{ADDR_DUTY,    16'h0077, 1'b0, 16'h0034, 16'h003F, 16'hABCD};
    tbl[4] = '{ADDR_STATUS,  16'hFFFF, 1'b1, 16'h0034, 16'h003F, 16'hABCD};
    tbl[5] = '{ADDR_BLINKEN, 16'h0005, 1'b1, 16'h0034, 16'h0005, 16'hABCD};
    tbl[6] = '{ADDR_PERIOD,  16'h0000, 1'b1, 16'h0034, 16'h0005, 16'h0000};
    tbl[7] = '{ADDR_DUTY,    16'h00FF, 1'b1, 16'h00FF, 16'h0005, 16'h0000};

    // ---- reset defaults ----
    Reset = 1'b0; LedGreen = 3'b101; LedRed = 3'b000;
    bus_if.Addr = ADDR_STATUS; bus_if.DataWr = '0; bus_if.Wr = 1'b0;
    bus_if.En = 1'b0; bus_if.Rd = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_pin_green", PinGreen, 3'b000);
    chk("rst_pin_red", PinRed, 3'b000);
    model_reset();
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("post_rst_green", PinGreen, 3'b101);
    end
    cyc(ADDR_DUTY, 16'h0, 1'b0, 1'b0);    chk("rst_duty", rd_val, 16'h00FF);
    cyc(ADDR_BLINKEN, 16'h0, 1'b0, 1'b0); chk("rst_blinken", rd_val, 16'h0000);
    cyc(ADDR_PERIOD, 16'h0, 1'b0, 1'b0);  chk("rst_period", rd_val, 16'h0000);

    // ---- register table ----
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].addr, tbl[i].data, 1'b1, tbl[i].en);
      cyc(ADDR_DUTY, 16'h0, 1'b0, 1'b0);    chk("tbl_duty", rd_val, tbl[i].exp_duty);
      cyc(ADDR_BLINKEN, 16'h0, 1'b0, 1'b0); chk("tbl_blinken", rd_val, tbl[i].exp_ben);
      cyc(ADDR_PERIOD, 16'h0, 1'b0, 1'b0);  chk("tbl_period", rd_val, tbl[i].exp_per);
    end

    // ---- duty shadowing ----
    LedGreen = 3'b001;
    cyc(ADDR_BLINKEN, 16'h0000, 1'b1, 1'b1);
    align_start();
    repeat (100) idle();
    cyc(ADDR_DUTY, 16'd64, 1'b1, 1'b1);
    n = 0; hi = 0;
    for (int i = 0; i < FR && (m_t % FR) != 0; i++) begin
      idle(); n++; hi += int'(PinGreen[0]);
    end
    chk("shadow_cur_frame", hi, n);
    frame_count(g0, g1);
    chk("duty64_high", g0, 64 * D);
    cyc(ADDR_DUTY, 16'd0, 1'b1, 1'b1);
    align_start();
    frame_count(g0, g1);
    chk("duty0_high", g0, 0);

    // ---- blink ----
    LedGreen = 3'b011;
    cyc(ADDR_DUTY, 16'h00FF, 1'b1, 1'b1);
    align_start();
    cyc(ADDR_BLINKEN, 16'h0001, 1'b1, 1'b1);
    cyc(ADDR_PERIOD, 16'd2, 1'b1, 1'b1);
    align_start();
    exp_b0 = '{FR, 0, 0, FR};
    for (int f = 0; f < 4; f++) begin
      frame_count(g0, g1);
      chk("blink_g0", g0, exp_b0[f]);
      chk("blink_g1", g1, FR);
    end

    // ---- PERIOD write restarts phase ----
    found = 1'b0;
    for (int i = 0; i < 4 * FR && !found; i++) begin
      idle();
      if (!model_phase()) found = 1'b1;
    end
    chk("find_phase0", found, 1'b1);
    repeat (10) idle();
    chk("pre_write_phase", rd_val[8], 1'b0);
    cyc(ADDR_PERIOD, 16'd3, 1'b1, 1'b1);
    idle();
    chk("period_wr_phase", rd_val[8], 1'b1);
    prev = rd_val[7:0]; wraps = 0; found = 1'b0;
    for (int i = 0; i < 6 * FR && !found; i++) begin
      idle();
      if (prev == 8'hFF && rd_val[7:0] == 8'h00) wraps++;
      prev = rd_val[7:0];
      if (!rd_val[8]) found = 1'b1;
    end
    chk("toggle_found", found, 1'b1);
    chk("toggle_frames", wraps, 3);

    // ---- DUTY write coincident with frame_end ----
    LedGreen = 3'b001;
    cyc(ADDR_BLINKEN, 16'h0000, 1'b1, 1'b1);
    cyc(ADDR_PERIOD, 16'h0000, 1'b1, 1'b1);
    align_start();
    cyc(ADDR_DUTY, 16'h0020, 1'b1, 1'b1);
    for (int i = 0; i < FR && (m_t % FR) != FR - 1; i++) idle();
    cyc(ADDR_DUTY, 16'h00C0, 1'b1, 1'b1);
    frame_count(g0, g1);
    chk("simul_old_duty", g0, 8'h20 * D);
    frame_count(g0, g1);
    chk("simul_new_duty", g0, 8'hC0 * D);
    cyc(ADDR_STATUS, 16'hFFFF, 1'b1, 1'b1);
    cyc(ADDR_DUTY, 16'h0, 1'b0, 1'b0);    chk("st_wr_duty", rd_val, 16'h00C0);
    cyc(ADDR_BLINKEN, 16'h0, 1'b0, 1'b0); chk("st_wr_blinken", rd_val, 16'h0000);
    cyc(ADDR_PERIOD, 16'h0, 1'b0, 1'b0);  chk("st_wr_period", rd_val, 16'h0000);

    // ---- randomized traffic ----
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 63) == 0) LedGreen = 3'($urandom);
      if ($urandom_range(0, 63) == 0) LedRed   = 3'($urandom);
      ra   = 2'($urandom);
      rdat = 16'($urandom);
      if (ra == ADDR_PERIOD) rdat = 16'($urandom_range(0, 2));
      cyc(ra, rdat, ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0));
    end

    // ---- async reset mid-operation ----
    LedGreen = 3'b111; LedRed = 3'b111;
    cyc(ADDR_BLINKEN, 16'h0000, 1'b1, 1'b1);
    cyc(ADDR_PERIOD, 16'h0000, 1'b1, 1'b1);
    cyc(ADDR_DUTY, 16'h00FF, 1'b1, 1'b1);
    align_start();
    repeat (3) idle();
    chk("pre_areset_green", PinGreen, 3'b111);
    #2 Reset = 1'b0;
    #1;
    chk("areset_green", PinGreen, 3'b000);
    chk("areset_red", PinRed, 3'b000);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    bus_if.Addr = ADDR_STATUS; bus_if.Wr = 1'b0;
    #1;
    chk("status_after_rst", bus_if.DataRd, 16'h0100);
    repeat (20) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_drive.md
Name: led_pwm_drive

Overview:
- Drives the six physical LED pins, downstream of the LED control register block.
- Consumes its LedGreen[2:0]/LedRed[2:0] enables and adds a global PWM brightness, plus per-LED blinking.
- Brightness and blink state are held in a small bus-mapped register file on the same peripheral bus: Addr, DataWr, DataRd, En, Rd, Wr.
- Pin outputs are registered so they are glitch-free.

Parameters:
CLK_DIV, 50, Clk cycles per PWM step (>=1).
PWM_BITS, 8, PWM counter/duty width (fixed at 8 in register map).

Ports:
Clk  input  1  system clock; all state on rising edge.
Reset  input  1  asynchronous, active-low reset (asserted when 0).
Addr  input  2  register select.
DataWr  input  16  write data.
DataRd  output  16  read data, combinational from Addr.
En  input  1  block select.
Rd  input  1  read strobe (no side effects).
Wr  input  1  write strobe, qualified by En.
LedGreen  input  3  green enables from LED control register.
LedRed  input  3  red enables from LED control register.
PinGreen  output  3  green LED drive, active-high, registered.
PinRed  output  3  red LED drive, active-high, registered.

Behaviour:
- Register map, written on posedge Clk when Wr & En:
  - Addr0 DUTY[7:0]: written into the pending-duty register.
  - Addr1 BLINKEN[5:0]: bits {red2..red0, green2..green0}.
  - Addr2 PERIOD[15:0]: blink half-period in PWM frames.
  - Addr3 STATUS: read-only; writes ignored.
- Reads:
  - Addr0 returns {8'h00, pending duty}.
  - Addr1 returns {10'h000, BLINKEN}.
  - Addr2 returns PERIOD.
  - Addr3 returns {7'h00, blink_phase, pwm_cnt[7:0]}.
- Reset (Reset=0, async):
  - Pending duty = active duty = 8'hFF.
  - BLINKEN=0, PERIOD=0.
  - Prescaler, pwm_cnt and blink_cnt = 0; blink_phase=1.
  - PinGreen = PinRed = 0.
  - Reset release mid-frame restarts from these values.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle the prescaler equals CLK_DIV-1.
- PWM:
  - pwm_cnt increments on tick, wrapping 255->0.
  - frame_end = tick & (pwm_cnt==255).
  - Active duty loads from pending duty only at frame_end (shadowed, no mid-frame glitch).
  - pwm_on = (active==8'hFF) | (pwm_cnt < active). Duty 0 = always off; 8'hFF = always on.
- Blink:
  - PERIOD==0: blink_phase forced 1 and blink_cnt held 0.
  - Otherwise, at frame_end blink_cnt increments.
  - When blink_cnt reaches PERIOD-1 at a frame_end, blink_cnt clears and blink_phase toggles.
  - A write to PERIOD clears blink_cnt and sets blink_phase=1 in the same edge. This overrides a simultaneous frame_end.
- Output, registered, one cycle latency from inputs/state:
  - Pin[i] <= Led[i] & pwm_on & (~BLINKEN[i] | blink_phase).
- Simultaneous events:
  - A DUTY write coincident with frame_end: the active duty loads the OLD pending value; the new value applies at the next frame_end.
- LedGreen/LedRed changes propagate to the pins in 1 Clk regardless of frame position.

Decomposition:
- Shared package holds:
  - Register address constants: ADDR_DUTY=0, ADDR_BLINKEN=1, ADDR_PERIOD=2, ADDR_STATUS=3.
  - Reset constants: DUTY_RST=8'hFF, PERIOD_RST=0.
  - LED bit ordering for BLINKEN.
- One natural sub-module: led_pwm_timebase, containing the prescaler, pwm_cnt, frame_end, active-duty shadow and pwm_on.
- The top level keeps the register file, blink logic and output register.

Test Plan:
- Reset defaults: CLK_DIV=2, Reset=0 then 1, LedGreen=3'b101.
  - Pins are 0 during reset.
  - 1 Clk after release: PinGreen=3'b101 constantly (duty FF).
  - Reads return DUTY=0x00FF, BLINKEN=0, PERIOD=0.
- Duty shadowing: write DUTY=64 mid-frame.
  - The current frame is unchanged.
  - From the next frame, PinGreen[0] is high for exactly 64×CLK_DIV cycles per 256×CLK_DIV frame.
  - DUTY=0 gives 0 high cycles.
- Blink: PERIOD=2, BLINKEN=6'b000001, LedGreen=3'b011, duty FF.
  - PinGreen[0] is high 2 frames, low 2 frames, repeating.
  - PinGreen[1] stays high.
- PERIOD write resets phase: write PERIOD=3 while blink_phase=0.
  - Next cycle STATUS[8]=1.
  - The next toggle occurs 3 frames later.
- Simultaneity: issue a DUTY write in the exact cycle of frame_end.
  - The new duty takes effect one frame later.
  - A write to Addr3 leaves all registers unchanged.
- Async reset mid-operation: assert Reset between clock edges while pins are high.
  - Pins go 0 immediately, without waiting for a Clk edge.
  - STATUS reads 16'h0100 after release before the first tick.
